// File: rtl/smm_pkg.sv
// Shared types and default sizing for the Strassen job sequencer slice.
package smm_pkg;

    localparam int unsigned SMM_DATAWIDTH = 32;
    localparam int unsigned SMM_BUSWIDTH  = SMM_DATAWIDTH * 16;
    localparam int unsigned SMM_LATENCY   = 4;
    localparam int unsigned SMM_CNTW      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } smm_seq_state_t;

endpackage

// File: rtl/smm_job_sequencer_if.sv
// One requester's job request and product response channel.
// master = requester side, slave = sequencer side.
interface smm_job_sequencer_if
    import smm_pkg::*;
#(
    parameter int unsigned BUSWIDTH = SMM_BUSWIDTH
);
    logic                req_valid;
    logic                req_ready;
    logic [BUSWIDTH-1:0] req_a;
    logic [BUSWIDTH-1:0] req_b;
    logic                req_sel;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [BUSWIDTH-1:0] rsp_c;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_c
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_c
    );
endinterface

// File: rtl/smm_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer moves past whoever was granted.
module smm_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_c_o
);
    // 0: requester 0 has priority, 1: requester 1 has priority
    logic ptr_q;

    // Pick the favoured requester when both ask, otherwise whoever asks.
    always_comb begin
        grant_c_o = 2'b00;
        if (req_i[0] && (!ptr_q || !req_i[1])) begin
            grant_c_o = 2'b01;
        end else if (req_i[1]) begin
            grant_c_o = 2'b10;
        end
    end

    // Favour the other requester after each accepted grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (advance_i && (grant_c_o != 2'b00)) begin
            ptr_q <= grant_c_o[0];
        end
    end
endmodule

// File: rtl/smm_job_sequencer.sv
// Shares one Strassen block-multiply datapath between two requesters,
// one job in flight at a time so the datapath mode stays stable.
// Optional build macro: SMM_SEQ_PERF_EN adds busy-cycle and job counters.
module smm_job_sequencer
    import smm_pkg::*;
#(
    parameter int unsigned DATAWIDTH = SMM_DATAWIDTH,
    parameter int unsigned BUSWIDTH  = DATAWIDTH * 16,
    parameter int unsigned LATENCY   = SMM_LATENCY
`ifdef SMM_SEQ_PERF_EN
    ,
    parameter int unsigned CNTW      = SMM_CNTW
`endif
) (
    input  logic                clk,
    input  logic                rst,
    smm_job_sequencer_if.slave  req0_if,
    smm_job_sequencer_if.slave  req1_if,
    output logic [BUSWIDTH-1:0] smm_a_o,
    output logic [BUSWIDTH-1:0] smm_b_o,
    output logic                smm_sel_o,
    output logic                smm_load_o,
    input  logic [BUSWIDTH-1:0] smm_c_i,
    output logic                busy_o
`ifdef SMM_SEQ_PERF_EN
    ,
    output logic [CNTW-1:0]     perf_busy_cycles_o,
    output logic [CNTW-1:0]     perf_jobs_done_o
`endif
);
    localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    smm_seq_state_t      state_q;
    logic                owner_q;
    logic [CW-1:0]       cnt_q;
    logic [BUSWIDTH-1:0] smm_a_q;
    logic [BUSWIDTH-1:0] smm_b_q;
    logic                smm_sel_q;
    logic                smm_load_q;
    logic                busy_q;
    logic [BUSWIDTH-1:0] rsp_c_q;
    logic [1:0]          rsp_valid_q;

    logic [1:0]          req_vld;
    logic [1:0]          grant;
    logic                accept;
    logic                owner_rdy;

    // Requests are only visible to the arbiter while idle and out of reset,
    // so nothing is acknowledged that the reset would then drop.
    assign req_vld   = {req1_if.req_valid, req0_if.req_valid}
                       & {2{(state_q == IDLE) && !rst}};
    assign accept    = |grant;
    assign owner_rdy = owner_q ? req1_if.rsp_ready : req0_if.rsp_ready;

    smm_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_vld),
        .advance_i (accept),
        .grant_c_o (grant)
    );

    // Ready is the grant itself, combinational from valid.
    assign req0_if.req_ready = grant[0];
    assign req1_if.req_ready = grant[1];

    // Job sequencing: accept, pulse load, wait out the latency, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            smm_a_q     <= '0;
            smm_b_q     <= '0;
            smm_sel_q   <= 1'b0;
            smm_load_q  <= 1'b0;
            busy_q      <= 1'b0;
            rsp_c_q     <= '0;
            rsp_valid_q <= 2'b00;
        end else begin
            smm_load_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q    <= grant[1];
                        smm_a_q    <= grant[1] ? req1_if.req_a   : req0_if.req_a;
                        smm_b_q    <= grant[1] ? req1_if.req_b   : req0_if.req_b;
                        smm_sel_q  <= grant[1] ? req1_if.req_sel : req0_if.req_sel;
                        smm_load_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= CW'(LATENCY - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_c_q     <= smm_c_i;
                        rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (owner_rdy) begin
                        rsp_valid_q <= 2'b00;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign smm_a_o    = smm_a_q;
    assign smm_b_o    = smm_b_q;
    assign smm_sel_o  = smm_sel_q;
    assign smm_load_o = smm_load_q;
    assign busy_o     = busy_q;

    assign req0_if.rsp_valid = rsp_valid_q[0];
    assign req1_if.rsp_valid = rsp_valid_q[1];
    assign req0_if.rsp_c     = rsp_c_q;
    assign req1_if.rsp_c     = rsp_c_q;

`ifdef SMM_SEQ_PERF_EN
    logic [CNTW-1:0] perf_busy_q;
    logic [CNTW-1:0] perf_jobs_q;
    logic            job_done;

    assign job_done = (state_q == RESP) && owner_rdy;

    // Saturating counters; a job occupies the unit from its accept cycle on.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_q <= '0;
            perf_jobs_q <= '0;
        end else begin
            if ((busy_q || accept) && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 1'b1;
            end
            if (job_done && (perf_jobs_q != '1)) begin
                perf_jobs_q <= perf_jobs_q + 1'b1;
            end
        end
    end

    assign perf_busy_cycles_o = perf_busy_q;
    assign perf_jobs_done_o   = perf_jobs_q;
`endif
endmodule
